// File: rtl/pipeline_handshake_divider_if.sv
// +----------------------------------------------------------------------------+
// | pipeline_handshake_divider_if                                              |
// | Input stream and collapsed output stream of pipeline_handshake_divider.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pipeline_handshake_divider_if #(
  parameter int WORD_WIDTH         = 8,
  parameter int REPEAT_COUNT_WIDTH = 3
);
  logic                          input_data_valid;
  logic                          input_data_ready;
  logic [WORD_WIDTH-1:0]         input_data;
  logic [REPEAT_COUNT_WIDTH-1:0] input_data_repeat_count;
  logic                          output_data_valid;
  logic                          output_data_ready;
  logic [WORD_WIDTH-1:0]         output_data;
  logic [REPEAT_COUNT_WIDTH-1:0] output_data_count;

  modport master (
    output input_data_valid, input_data, input_data_repeat_count, output_data_ready,
    input  input_data_ready, output_data_valid, output_data, output_data_count
  );

  modport slave (
    input  input_data_valid, input_data, input_data_repeat_count, output_data_ready,
    output input_data_ready, output_data_valid, output_data, output_data_count
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_handshake_divider.sv
// +----------------------------------------------------------------------------+
// | pipeline_handshake_divider                                                 |
// | Collapses a group of N input handshakes into one output handshake.         |
// | Option: PIPELINE_HANDSHAKE_DIVIDER_XOR_REDUCE_EN (XOR-reduce the group).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipeline_handshake_divider #(
  parameter int WORD_WIDTH         = 8,
  parameter int MAX_REPEAT_COUNT   = 4,
  parameter int REPEAT_COUNT_WIDTH = $clog2(MAX_REPEAT_COUNT) + 1
) (
  input  wire                            clock,
  input  wire                            clear_n,
  pipeline_handshake_divider_if.slave    bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  localparam logic [REPEAT_COUNT_WIDTH-1:0] c_MAX_COUNT = REPEAT_COUNT_WIDTH'(MAX_REPEAT_COUNT);

  logic [1:0]                    state_q, state_d;
  logic                          ready_q, ready_d;
  logic                          valid_q, valid_d;
  logic [WORD_WIDTH-1:0]         acc_q, acc_d;
  logic [REPEAT_COUNT_WIDTH-1:0] count_q, count_d;
  logic [REPEAT_COUNT_WIDTH-1:0] remaining_q, remaining_d;

  logic                          w_in_hs;
  logic                          w_out_hs;
  logic [REPEAT_COUNT_WIDTH-1:0] w_clamped;
  logic [WORD_WIDTH-1:0]         w_fold;

  assign w_in_hs   = bus.input_data_valid & ready_q;
  assign w_out_hs  = valid_q & bus.output_data_ready;
  assign w_clamped = (bus.input_data_repeat_count > c_MAX_COUNT) ? c_MAX_COUNT
                                                                 : bus.input_data_repeat_count;

`ifdef PIPELINE_HANDSHAKE_DIVIDER_XOR_REDUCE_EN
  assign w_fold = acc_q ^ bus.input_data;
`else
  assign w_fold = bus.input_data;
`endif

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    valid_d     = valid_q;
    acc_d       = acc_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
        // A zero count sinks the word without touching any output state.
        if (w_in_hs && (w_clamped != '0)) begin
          acc_d   = bus.input_data;
          count_d = w_clamped;
          if (w_clamped == REPEAT_COUNT_WIDTH'(1)) begin
            remaining_d = '0;
            state_d     = HOLD;
            ready_d     = 1'b0;
            valid_d     = 1'b1;
          end else begin
            remaining_d = w_clamped - REPEAT_COUNT_WIDTH'(1);
            state_d     = COLLECT;
          end
        end
      end
      COLLECT: begin
        ready_d = 1'b1;
        if (w_in_hs) begin
          acc_d       = w_fold;
          remaining_d = remaining_q - REPEAT_COUNT_WIDTH'(1);
          if (remaining_q == REPEAT_COUNT_WIDTH'(1)) begin
            state_d = HOLD;
            ready_d = 1'b0;
            valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        ready_d = 1'b0;
        valid_d = 1'b1;
        if (w_out_hs) begin
          state_d = IDLE;
          ready_d = 1'b1;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
    end
  end

  // The accumulator only changes outside HOLD, so it doubles as the output register.
  assign bus.input_data_ready  = ready_q;
  assign bus.output_data_valid = valid_q;
  assign bus.output_data       = acc_q;
  assign bus.output_data_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_handshake_divider.sv
// +----------------------------------------------------------------------------+
// | tb_pipeline_handshake_divider                                              |
// | Self-checking bench: vector table, corner sequences, random + ref model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_handshake_divider;

  localparam int W    = 8;
  localparam int MAXC = 4;
  localparam int RCW  = 3;

  logic clk     = 1'b0;
  logic clear_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_handshake_divider_if #(.WORD_WIDTH(W), .REPEAT_COUNT_WIDTH(RCW)) bus ();

  pipeline_handshake_divider #(
    .WORD_WIDTH        (W),
    .MAX_REPEAT_COUNT  (MAXC),
    .REPEAT_COUNT_WIDTH(RCW)
  ) dut (
    .clock  (clk),
    .clear_n(clear_n),
    .bus    (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          cnt;
    int          n;
    logic [31:0] w;
    bit          out;
    logic [7:0]  exp_last;
    logic [7:0]  exp_xor;
    int          exp_cnt;
  } vec_t;

  typedef struct packed {
    logic [W-1:0]   d;
    logic [RCW-1:0] c;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] grp_words[$];
  int         grp_need = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: actual=timeout required=handshake t=%0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input int cnt);
    int t;
    bit done;
    t    = 0;
    done = 1'b0;
    bus.input_data_valid        = 1'b1;
    bus.input_data              = d;
    bus.input_data_repeat_count = RCW'(cnt);
    while (!done) begin
      if (t >= 40) begin
        timeout("send_word");
        done = 1'b1;
      end else begin
        if (bus.input_data_ready) done = 1'b1;
        tick();
        t++;
      end
    end
    bus.input_data_valid = 1'b0;
  endtask

  function automatic logic [7:0] pick(input logic [7:0] last_v, input logic [7:0] xor_v);
`ifdef PIPELINE_HANDSHAKE_DIVIDER_XOR_REDUCE_EN
    return xor_v;
`else
    return last_v;
`endif
  endfunction

  task automatic run_vec(input vec_t v, input string name);
    logic [31:0] w;
    w = v.w;
    for (int i = 0; i < v.n; i++) send_word(w[8*i +: 8], (i == 0) ? v.cnt : 0);
    if (v.out) begin
      chk({name, "_valid"}, bus.output_data_valid, 1);
      chk({name, "_ready"}, bus.input_data_ready, 0);
      chk({name, "_data"},  bus.output_data, pick(v.exp_last, v.exp_xor));
      chk({name, "_count"}, bus.output_data_count, v.exp_cnt);
      tick();
    end
    chk({name, "_idle_valid"}, bus.output_data_valid, 0);
    chk({name, "_idle_ready"}, bus.input_data_ready, 1);
  endtask

  // Reference model: collects the accepted words of each group as a list and
  // reduces the list when it reaches the clamped group size.
  always @(posedge clk) begin
    if (mon_en) begin
      bit ih, oh;
      int c;
      logic [7:0] r;
      ih = bus.input_data_valid && bus.input_data_ready;
      oh = bus.output_data_valid && bus.output_data_ready;
      chk("rnd_hs_exclusive", {31'd0, ih && oh}, 0);
      if (oh) begin
        if (exp_q.size() == 0) begin
          chk("rnd_out_expected", 32'(exp_q.size()), 1);
        end else begin
          chk("rnd_data",  bus.output_data, exp_q[0].d);
          chk("rnd_count", bus.output_data_count, exp_q[0].c);
          void'(exp_q.pop_front());
        end
      end
      if (ih) begin
        if (grp_need == 0) begin
          c = int'(bus.input_data_repeat_count);
          if (c > MAXC) c = MAXC;
          if (c != 0) begin
            grp_need = c;
            grp_words.delete();
            grp_words.push_back(bus.input_data);
          end
        end else begin
          grp_words.push_back(bus.input_data);
        end
        if (grp_need != 0 && grp_words.size() == grp_need) begin
`ifdef PIPELINE_HANDSHAKE_DIVIDER_XOR_REDUCE_EN
          r = '0;
          foreach (grp_words[k]) r = r ^ grp_words[k];
`else
          r = grp_words[$];
`endif
          exp_q.push_back('{d: r, c: RCW'(grp_need)});
          grp_need = 0;
        end
      end
      #2;
      chk("rnd_valid", bus.output_data_valid, (exp_q.size() != 0));
      chk("rnd_ready", bus.input_data_ready, (exp_q.size() == 0));
    end
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{cnt:3, n:3, w:32'h00332211, out:1'b1, exp_last:8'h33, exp_xor:8'h00, exp_cnt:3};
    vecs[1] = '{cnt:1, n:1, w:32'h0000005A, out:1'b1, exp_last:8'h5A, exp_xor:8'h5A, exp_cnt:1};
    vecs[2] = '{cnt:2, n:2, w:32'h0000C33C, out:1'b1, exp_last:8'hC3, exp_xor:8'hFF, exp_cnt:2};
    vecs[3] = '{cnt:0, n:1, w:32'h000000AA, out:1'b0, exp_last:8'h00, exp_xor:8'h00, exp_cnt:0};
    vecs[4] = '{cnt:1, n:1, w:32'h00000077, out:1'b1, exp_last:8'h77, exp_xor:8'h77, exp_cnt:1};
    vecs[5] = '{cnt:5, n:4, w:32'h08040201, out:1'b1, exp_last:8'h08, exp_xor:8'h0F, exp_cnt:4};
    vecs[6] = '{cnt:7, n:4, w:32'h80402010, out:1'b1, exp_last:8'h80, exp_xor:8'hF0, exp_cnt:4};

    bus.input_data_valid        = 1'b0;
    bus.input_data              = '0;
    bus.input_data_repeat_count = '0;
    bus.output_data_ready       = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", bus.input_data_ready, 0);
      chk("rst_valid", bus.output_data_valid, 0);
      chk("rst_data",  bus.output_data, 0);
      chk("rst_count", bus.output_data_count, 0);
    end
    clear_n = 1'b1;
    chk("rel_ready_before_edge", bus.input_data_ready, 0);
    tick();
    chk("rel_ready_after_edge", bus.input_data_ready, 1);

    bus.output_data_ready = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: output held for five stalled cycles, then one handshake.
    bus.output_data_ready = 1'b0;
    send_word(8'h66, 2);
    send_word(8'h99, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.output_data_valid, 1);
      chk("bp_ready", bus.input_data_ready, 0);
      chk("bp_data",  bus.output_data, pick(8'h99, 8'hFF));
      chk("bp_count", bus.output_data_count, 2);
      tick();
    end
    bus.output_data_ready = 1'b1;
    tick();
    chk("bp_release_valid", bus.output_data_valid, 0);
    chk("bp_release_ready", bus.input_data_ready, 1);
    tick();
    chk("bp_single_hs", bus.output_data_valid, 0);

    // Reset in the middle of a four-word group discards it.
    send_word(8'h01, 4);
    send_word(8'h02, 0);
    #2;
    clear_n = 1'b0;
    #1;
    chk("mid_rst_ready", bus.input_data_ready, 0);
    chk("mid_rst_valid", bus.output_data_valid, 0);
    chk("mid_rst_data",  bus.output_data, 0);
    chk("mid_rst_count", bus.output_data_count, 0);
    tick();
    clear_n = 1'b1;
    tick();
    chk("mid_rst_recover_ready", bus.input_data_ready, 1);
    chk("mid_rst_no_output", bus.output_data_valid, 0);
    run_vec('{cnt:2, n:2, w:32'h0000A55A, out:1'b1, exp_last:8'hA5, exp_xor:8'hFF, exp_cnt:2},
            "post_rst");

    mon_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bus.input_data_valid        = ($urandom_range(0, 3) != 0);
      bus.input_data              = W'($urandom);
      bus.input_data_repeat_count = RCW'($urandom_range(0, 7));
      bus.output_data_ready       = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.input_data_valid  = 1'b0;
    bus.output_data_ready = 1'b1;
    repeat (10) tick();
    #3;
    mon_en = 1'b0;
    chk("rnd_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
